// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one read per accepted request, holds the result until decode consumes it.
// Optional misaligned-address fault detection is enabled with macro FETCH_MISALIGN_CHECK_EN.
module instruction_fetch_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_req,
  output logic        fetch_ready,
  input  logic        flush,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_valid,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [1:0]  instr_fault
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, HOLD, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt;
  logic            accept;
  logic            timeout;
  logic            misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = (fetch_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign fetch_ready = (state == IDLE) || ((state == HOLD) && instr_ready && !flush);
  // flush overrides a request even while fetch_ready is high in IDLE
  assign accept      = fetch_req && fetch_ready && !flush;
  assign timeout     = (wait_cnt == CW'(MAX_WAIT));
  assign instr_valid = (state == HOLD);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = misaligned ? HOLD : WAIT_MEM;
      end
      WAIT_MEM: begin
        if (flush)                        state_nxt = DRAIN;
        else if (mem_rd_valid || timeout) state_nxt = HOLD;
      end
      HOLD: begin
        if (flush)            state_nxt = IDLE;
        else if (accept)      state_nxt = misaligned ? HOLD : WAIT_MEM;
        else if (instr_ready) state_nxt = IDLE;
      end
      DRAIN: begin
        if (!flush && (mem_rd_valid || timeout)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      instr_data  <= '0;
      instr_pc    <= '0;
      instr_fault <= 2'b00;
      wait_cnt    <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      if (accept) begin
        instr_pc <= fetch_addr;
        wait_cnt <= '0;
        if (misaligned) begin
          instr_fault <= 2'b01;
          instr_data  <= '0;
        end else begin
          mem_rd_en <= 1'b1;
          mem_addr  <= {fetch_addr[31:2], 2'b00};
        end
      end else if ((state == WAIT_MEM) || (state == DRAIN)) begin
        if (!timeout) wait_cnt <= wait_cnt + CW'(1);
        // only a live WAIT_MEM response updates the held result; DRAIN discards it
        if ((state == WAIT_MEM) && !flush) begin
          if (mem_rd_valid) begin
            instr_data  <= mem_rd_data;
            instr_fault <= 2'b00;
          end else if (timeout) begin
            instr_data  <= '0;
            instr_fault <= 2'b10;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit (MAX_WAIT=4 so the timeout is reachable quickly).
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fetch_addr;
  logic        fetch_req;
  logic        fetch_ready;
  logic        flush;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [1:0]  instr_fault;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch_unit #(.MAX_WAIT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .fetch_addr   (fetch_addr),
    .fetch_req    (fetch_req),
    .fetch_ready  (fetch_ready),
    .flush        (flush),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .instr_fault  (instr_fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic handshake();
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; fetch_addr = '0; fetch_req = 1'b0; flush = 1'b0;
    mem_rd_data = '0; mem_rd_valid = 1'b0; instr_ready = 1'b0;
    #3;
    check("rst_valid", instr_valid, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", instr_data, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_fault", instr_fault, 0);
    repeat (2) cyc();
    reset = 1'b1;
    cyc();

    // basic fetch, response 3 cycles after the read strobe
    fetch_addr = 32'h0000_0100; fetch_req = 1'b1; #1;
    check("t1_ready_idle", fetch_ready, 1);
    cyc();
    fetch_req = 1'b0;
    check("t1_rd_en", mem_rd_en, 1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_valid_wait", instr_valid, 0);
    check("t1_ready_wait", fetch_ready, 0);
    cyc();
    check("t1_rd_en_pulse", mem_rd_en, 0);
    cyc();
    check("t1_rd_en_low", mem_rd_en, 0);
    cyc();
    mem_rd_valid = 1'b1; mem_rd_data = 32'h0050_0093;
    cyc();
    mem_rd_valid = 1'b0; mem_rd_data = '0;
    check("t1_valid", instr_valid, 1);
    check("t1_pc", instr_pc, 32'h100);
    check("t1_data", instr_data, 32'h0050_0093);
    check("t1_fault", instr_fault, 0);

    // stall in HOLD, then back-to-back fetch on the handshake
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t2_hold_valid", instr_valid, 1);
      check("t2_hold_data", instr_data, 32'h0050_0093);
      check("t2_hold_pc", instr_pc, 32'h100);
      check("t2_hold_fault", instr_fault, 0);
    end
    check("t2_ready_stall", fetch_ready, 0);
    instr_ready = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0000_0104; #1;
    check("t2_ready_hs", fetch_ready, 1);
    cyc();
    instr_ready = 1'b0; fetch_req = 1'b0;
    check("t2_rd_en", mem_rd_en, 1);
    check("t2_mem_addr", mem_addr, 32'h104);
    check("t2_valid_drop", instr_valid, 0);
    cyc();
    mem_rd_valid = 1'b1; mem_rd_data = 32'h0010_0193;
    cyc();
    mem_rd_valid = 1'b0;
    check("t2_valid", instr_valid, 1);
    check("t2_data", instr_data, 32'h0010_0193);
    check("t2_pc", instr_pc, 32'h104);
    handshake();
    check("t2_idle_valid", instr_valid, 0);
    check("t2_idle_ready", fetch_ready, 1);

    // timeout with no response, then a late response is ignored
    fetch_addr = 32'h0000_0180; fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    check("t3_rd_en", mem_rd_en, 1);
    repeat (3) cyc();
    check("t3_not_yet", instr_valid, 0);
    for (int i = 0; i < 6; i++) begin
      if (instr_valid) break;
      cyc();
    end
    check("t3_timeout_seen", instr_valid, 1);
    check("t3_fault", instr_fault, 2'b10);
    check("t3_data", instr_data, 0);
    check("t3_pc", instr_pc, 32'h180);
    mem_rd_valid = 1'b1; mem_rd_data = 32'h0000_ABCD;
    cyc();
    mem_rd_valid = 1'b0;
    check("t3_late_data", instr_data, 0);
    check("t3_late_fault", instr_fault, 2'b10);
    handshake();

    // flush during WAIT_MEM drains the stale response
    fetch_addr = 32'h0000_01C0; fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0; #1;
    check("t4_drain_ready", fetch_ready, 0);
    check("t4_drain_valid", instr_valid, 0);
    cyc();
    mem_rd_valid = 1'b1; mem_rd_data = 32'hDEAD_BEEF;
    cyc();
    mem_rd_valid = 1'b0; #1;
    check("t4_no_valid", instr_valid, 0);
    check("t4_idle_ready", fetch_ready, 1);
    fetch_addr = 32'h0000_0200; fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    check("t4_rd_en", mem_rd_en, 1);
    check("t4_mem_addr", mem_addr, 32'h200);
    cyc();
    mem_rd_valid = 1'b1; mem_rd_data = 32'h00A0_0113;
    cyc();
    mem_rd_valid = 1'b0;
    check("t4_valid", instr_valid, 1);
    check("t4_data", instr_data, 32'h00A0_0113);
    check("t4_pc", instr_pc, 32'h200);

    // flush in HOLD without a handshake drops the held instruction
    flush = 1'b1;
    cyc();
    flush = 1'b0; #1;
    check("t6_flush_hold", instr_valid, 0);
    check("t6_idle_ready", fetch_ready, 1);

    // flush beats a request in IDLE
    flush = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0000_0240;
    cyc();
    flush = 1'b0; fetch_req = 1'b0;
    check("t7_no_rd_en", mem_rd_en, 0);
    check("t7_pc_kept", instr_pc, 32'h200);
    cyc();
    check("t7_no_valid", instr_valid, 0);

    // misaligned request
    fetch_addr = 32'h0000_0102; fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("t5_no_rd_en", mem_rd_en, 0);
    check("t5_valid", instr_valid, 1);
    check("t5_fault", instr_fault, 2'b01);
    check("t5_pc", instr_pc, 32'h102);
    check("t5_data", instr_data, 0);
`else
    check("t5_rd_en", mem_rd_en, 1);
    check("t5_mem_addr", mem_addr, 32'h100);
    cyc();
    mem_rd_valid = 1'b1; mem_rd_data = 32'h0000_0013;
    cyc();
    mem_rd_valid = 1'b0;
    check("t5_valid", instr_valid, 1);
    check("t5_fault", instr_fault, 0);
    check("t5_pc", instr_pc, 32'h102);
    check("t5_data", instr_data, 32'h0000_0013);
`endif
    handshake();

    // reset mid-fetch, then a late response after release
    fetch_addr = 32'h0000_0300; fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    check("t8_rd_en", mem_rd_en, 1);
    cyc();
    reset = 1'b0; #1;
    check("t8_rst_rd_en", mem_rd_en, 0);
    check("t8_rst_addr", mem_addr, 0);
    check("t8_rst_pc", instr_pc, 0);
    check("t8_rst_valid", instr_valid, 0);
    check("t8_rst_fault", instr_fault, 0);
    cyc();
    reset = 1'b1;
    cyc();
    mem_rd_valid = 1'b1; mem_rd_data = 32'h1234_5678;
    cyc();
    mem_rd_valid = 1'b0; #1;
    check("t8_late_valid", instr_valid, 0);
    check("t8_late_data", instr_data, 0);
    check("t8_idle_ready", fetch_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
